// File: rtl/rgb888_to_rgb444_dither_if.sv
// rgb888_to_rgb444_dither_if: pixel stream in (RGB888) and out (RGB444) with valid/ready handshakes
interface rgb888_to_rgb444_dither_if;
    logic [7:0]  i_r_data;
    logic [7:0]  i_g_data;
    logic [7:0]  i_b_data;
    logic        i_valid;
    logic        i_sof;
    logic        i_eol;
    logic        o_ready;
    logic [11:0] o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_eol;
    logic        i_ready;

    modport slave (
        input  i_r_data, i_g_data, i_b_data, i_valid, i_sof, i_eol, i_ready,
        output o_ready, o_data, o_valid, o_sof, o_eol
    );

    modport master (
        output i_r_data, i_g_data, i_b_data, i_valid, i_sof, i_eol, i_ready,
        input  o_ready, o_data, o_valid, o_sof, o_eol
    );
endinterface

// File: rtl/rgb888_to_rgb444_dither.sv
// rgb888_to_rgb444_dither: RGB888 -> RGB444 with optional 4x4 Bayer dither, output register plus skid buffer
module rgb888_to_rgb444_dither #(
    parameter int DITHER = 1
) (
    input logic                      i_p_clk,
    input logic                      i_rstn,
    rgb888_to_rgb444_dither_if.slave bus
);
    localparam logic [63:0] BAYER = 64'h5D7F_91B3_6E4C_A280;

    logic [1:0]  x_cnt, y_cnt, xe, ye;
    logic [3:0]  t;
    logic [11:0] pix;
    logic        accept, free;
    logic        skid_full, skid_sof, skid_eol;
    logic [11:0] skid_data;

    // q = c - c[7:4] maps 0..255 onto 0..240 so that c4*17 lands on c4*16 exactly
    function automatic logic [3:0] quant(input logic [7:0] c, input logic [3:0] th);
        return 4'((c - {4'd0, c[7:4]} + {4'd0, th}) >> 4);
    endfunction

    // effective position (sof forces origin) and per-pixel threshold
    always_comb begin
        xe  = bus.i_sof ? 2'd0 : x_cnt;
        ye  = bus.i_sof ? 2'd0 : y_cnt;
        t   = (DITHER != 0) ? BAYER[{ye, xe, 2'b00} +: 4] : 4'd8;
        pix = {quant(bus.i_r_data, t), quant(bus.i_g_data, t), quant(bus.i_b_data, t)};
    end

    assign accept = bus.i_valid & bus.o_ready;
    assign free   = !bus.o_valid | bus.i_ready;

    // screen position tracking, advanced only by accepted beats
    always_ff @(posedge i_p_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_cnt <= 2'd0;
            y_cnt <= 2'd0;
        end else if (accept) begin
            x_cnt <= bus.i_eol ? 2'd0 : xe + 2'd1;
            y_cnt <= bus.i_eol ? ye + 2'd1 : ye;
        end
    end

    // output register with one-entry skid; o_ready mirrors skid emptiness
    always_ff @(posedge i_p_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_valid <= 1'b0;
            bus.o_data  <= 12'h000;
            bus.o_sof   <= 1'b0;
            bus.o_eol   <= 1'b0;
            bus.o_ready <= 1'b0;
            skid_full   <= 1'b0;
            skid_data   <= 12'h000;
            skid_sof    <= 1'b0;
            skid_eol    <= 1'b0;
        end else if (free) begin
            bus.o_ready <= 1'b1;
            skid_full   <= 1'b0;
            if (skid_full) begin
                bus.o_valid <= 1'b1;
                bus.o_data  <= skid_data;
                bus.o_sof   <= skid_sof;
                bus.o_eol   <= skid_eol;
            end else begin
                bus.o_valid <= accept;
                bus.o_data  <= accept ? pix : 12'h000;
                bus.o_sof   <= accept & bus.i_sof;
                bus.o_eol   <= accept & bus.i_eol;
            end
        end else if (accept) begin
            skid_full   <= 1'b1;
            skid_data   <= pix;
            skid_sof    <= bus.i_sof;
            skid_eol    <= bus.i_eol;
            bus.o_ready <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rgb888_to_rgb444_dither.sv
// tb_rgb888_to_rgb444_dither: directed vectors against both DITHER settings
module tb_rgb888_to_rgb444_dither;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rgb888_to_rgb444_dither_if b0 ();
    rgb888_to_rgb444_dither_if b1 ();

    rgb888_to_rgb444_dither #(.DITHER(0)) dut0 (.i_p_clk(clk), .i_rstn(rstn), .bus(b0));
    rgb888_to_rgb444_dither #(.DITHER(1)) dut1 (.i_p_clk(clk), .i_rstn(rstn), .bus(b1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic v, input logic sof, input logic eol, input logic rdy);
        b0.i_r_data = r; b0.i_g_data = g; b0.i_b_data = b;
        b0.i_valid = v; b0.i_sof = sof; b0.i_eol = eol; b0.i_ready = rdy;
        b1.i_r_data = r; b1.i_g_data = g; b1.i_b_data = b;
        b1.i_valid = v; b1.i_sof = sof; b1.i_eol = eol; b1.i_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] e88 [4] = '{12'h888, 12'h888, 12'h888, 12'h888};
    logic [11:0] e80 [4] = '{12'h777, 12'h888, 12'h777, 12'h888};
    logic        ls_sof [12] = '{1,0,0,0,0,0,0,0,1,0,1,0};
    logic        ls_eol [12] = '{0,0,0,0,0,1,0,0,0,0,1,0};
    logic [11:0] ls_exp [12] = '{12'h777, 12'h888, 12'h778, 12'h888, 12'h777, 12'h888,
                                 12'h888, 12'h788, 12'h777, 12'h888, 12'h777, 12'h888};
    logic [11:0] sb [$];
    logic [11:0] held, exp_pix;
    logic [7:0]  v8;
    logic [3:0]  c4;
    logic        was_held, rdy, vld;
    int          k;

    initial begin
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #12;
        check("rst_valid", b1.o_valid, 0);
        check("rst_ready", b1.o_ready, 0);
        check("rst_data", b1.o_data, 0);
        rstn = 1'b1;
        step();
        check("ready_after_rst", b1.o_ready, 1);
        check("ready_after_rst0", b0.o_ready, 1);

        drive(8'd255, 8'd136, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check("round_f80", b0.o_data, 12'hF80);
        check("round_valid", b0.o_valid, 1);
        check("round_sof", b0.o_sof, 1);
        drive(8'd8, 8'd7, 8'd248, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check("round_10f", b0.o_data, 12'h10F);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("drain_valid", b0.o_valid, 0);
        check("drain_data", b0.o_data, 0);

        for (int i = 0; i < 4; i++) begin
            drive(8'h88, 8'h88, 8'h88, 1'b1, i == 0, 1'b0, 1'b1);
            step();
            check("bayer_88", b1.o_data, e88[i]);
        end
        for (int i = 0; i < 4; i++) begin
            drive(8'h80, 8'h80, 8'h80, 1'b1, i == 0, 1'b0, 1'b1);
            step();
            check("bayer_80", b1.o_data, e80[i]);
        end

        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 16; p++) begin
                v8 = 8'(c * 17);
                c4 = 4'(c);
                drive(v8, v8, v8, 1'b1, p == 0, (p % 4) == 3, 1'b1);
                step();
                check("sweep_d1", b1.o_data, {c4, c4, c4});
                check("sweep_d0", b0.o_data, {c4, c4, c4});
            end
        end

        for (int i = 0; i < 12; i++) begin
            drive(8'h80, 8'h84, 8'h86, 1'b1, ls_sof[i], ls_eol[i], 1'b1);
            step();
            check("line_frame", b1.o_data, ls_exp[i]);
            check("line_eol", b1.o_eol, ls_eol[i]);
        end
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        k = 1;
        was_held = 1'b0;
        held = 12'h000;
        for (int cyc = 0; cyc < 12; cyc++) begin
            rdy = cyc >= 3;
            vld = cyc < 9;
            v8 = 8'(k * 17);
            drive(v8, v8, v8, vld, 1'b0, 1'b0, rdy);
            if (was_held) check("bp_stable", b0.o_data, held);
            if (cyc == 2) check("bp_ready_low", b0.o_ready, 0);
            if (b0.o_valid && rdy) begin
                if (sb.size() > 0) begin
                    exp_pix = sb.pop_front();
                    check("bp_order", b0.o_data, exp_pix);
                end else begin
                    check("bp_dup", b0.o_valid, 0);
                end
            end
            was_held = b0.o_valid && !rdy;
            held = b0.o_data;
            if (vld && b0.o_ready) begin
                c4 = 4'(k);
                sb.push_back({c4, c4, c4});
                k++;
            end
            step();
        end
        check("bp_drained", sb.size(), 0);
        check("bp_accepts", k, 8);
        check("bp_idle_valid", b0.o_valid, 0);

        drive(8'h11, 8'h11, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(8'h22, 8'h22, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("skid_full_ready", b0.o_ready, 0);
        check("skid_held_sof", b0.o_sof, 1);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_valid", b0.o_valid, 0);
        check("arst_data", b0.o_data, 0);
        check("arst_sof", b0.o_sof, 0);
        check("arst_eol", b0.o_eol, 0);
        check("arst_ready", b0.o_ready, 0);
        check("arst_valid1", b1.o_valid, 0);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rstn = 1'b1;
        step();
        check("rel_ready", b0.o_ready, 1);
        check("rel_valid", b0.o_valid, 0);
        drive(8'h33, 8'h33, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check("rel_first_d0", b0.o_data, 12'h333);
        check("rel_first_d1", b1.o_data, 12'h333);
        check("rel_first_v", b0.o_valid, 1);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("rel_no_stale", b0.o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rgb888_to_rgb444_dither.md
RGB888_TO_RGB444_DITHER -- requirements
Module: rgb888_to_rgb444_dither

Interface
REQ-001 Parameter DITHER, default 1: 1 = 4x4 ordered (Bayer) dither; 0 = plain round-to-nearest.
REQ-002 i_p_clk  input  1  the block's one clock; all state changes on its rising edge.
REQ-003 i_rstn  input  1  asynchronous, active-low reset.
REQ-004 i_r_data  input  8  red component of the input pixel.
REQ-005 i_g_data  input  8  green component of the input pixel.
REQ-006 i_b_data  input  8  blue component of the input pixel.
REQ-007 i_valid  input  1  upstream pixel valid.
REQ-008 i_sof  input  1  start-of-frame marker; qualified by i_valid.
REQ-009 i_eol  input  1  end-of-line marker; qualified by i_valid.
REQ-010 o_ready  output  1  block can accept a beat; registered.
REQ-011 o_data  output  12  packed pixel {R[11:8], G[7:4], B[3:0]}.
REQ-012 o_valid  output  1  o_data valid.
REQ-013 o_sof  output  1  i_sof delayed with its pixel.
REQ-014 o_eol  output  1  i_eol delayed with its pixel.
REQ-015 i_ready  input  1  downstream accepts o_data.

Function
REQ-016 Input accept = i_valid & o_ready; output transfer = o_valid & i_ready.
REQ-017 Quantiser per component c8 (all components): q = c8 - c8[7:4], 9-bit unsigned, range 0..240.
REQ-018 DITHER=0: c4 = (q + 8) >> 4.
REQ-019 DITHER=1: c4 = (q + T) >> 4, where T = B[y][x]; q + T never exceeds 255, so no saturation.
REQ-020 Bayer rows: y0 = {0,8,2,10}; y1 = {12,4,14,6}; y2 = {3,11,1,9}; y3 = {15,7,13,5}; index x within each row.
REQ-021 Round trip is exact: any c8 = c4*17 SHALL yield c4, for both DITHER values.
REQ-022 Position counters x[1:0], y[1:0] advance only on an accepted beat.
REQ-023 A beat with i_sof uses x=0, y=0, overriding current counter values.
REQ-024 After an accepted beat with i_eol: x <= 0 and y <= y+1 (mod 4); i_sof on the same beat gives y <= 1.
REQ-025 After an accepted beat without i_eol: x <= x+1 (mod 4); y unchanged.
REQ-026 Latency: a beat accepted at edge k SHALL present on o_data/o_valid/o_sof/o_eol after edge k when the output register is free.
REQ-027 Output register plus one-entry skid buffer, so a stall never drops a beat.
REQ-028 o_ready SHALL be 1 whenever the skid buffer is empty, and 0 otherwise.
REQ-029 Beat accepted while output is held (o_valid & !i_ready): the beat SHALL go to the skid buffer and o_ready SHALL drop on the next edge.
REQ-030 On output transfer with the skid buffer full: the skid entry moves to the output and o_ready returns to 1.
REQ-031 Held output: o_data/o_sof/o_eol SHALL stay stable while o_valid & !i_ready.
REQ-032 Output drained with no new beat: o_valid SHALL be 0 and o_data SHALL be 12'h000.
REQ-033 Beats SHALL leave in acceptance order; no duplication or loss under any i_ready pattern.

Reset
REQ-034 While i_rstn = 0, asynchronously: o_valid=0, o_data=0, o_sof=0, o_eol=0, o_ready=0, skid empty, x=0, y=0.
REQ-035 o_ready SHALL be 1 on the first edge after reset release.
REQ-036 Reset asserted mid-stream SHALL discard the output register and the skid buffer contents with no partial output.

Verification
REQ-037 DITHER=0, i_ready=1: pixel (255,136,0) -> o_data=12'hF80 one cycle later; (8,7,248) -> 12'h10F.
REQ-038 DITHER=1: sof row of 4 pixels with all components = 0x88, x=0..3 (T=0,8,2,10) -> o_data = 12'h888, 12'h888, 12'h888, 12'h888; all components = 0x80 (q=120) -> 12'h777, 12'h888, 12'h777, 12'h888.
REQ-039 DITHER=1: sweep all c4*17 values at all 16 (x,y) positions -> o_data components = c4 exactly.
REQ-040 Backpressure: i_valid held 1, i_ready=0 for 3 cycles then 1 -> o_ready falls after the second accepted beat; all beats emerge in order with no loss or duplication; o_data stays stable while stalled.
REQ-041 Line/frame: eol after pixel 5, then sof mid-line -> the next pixel uses (x,y)=(0,1), and the sof pixel uses (0,0).
REQ-042 Assert i_rstn=0 asynchronously with the skid buffer full -> all outputs 0 immediately; after release o_ready=1 and the first output is the first new beat.
